seq_alu: RTL and testbench

- Parametrised, handshaked successor to the combinational single-cycle ALU.
- Keeps the existing 4-bit ALUOp encoding and adds signed/unsigned divide and remainder.
- Multiply and divide run iteratively (one bit per cycle); all other ops complete in one registered cycle.
- Sits between the decode/register-read stage and writeback, and stalls the core via in_ready while an iterative op runs.

---
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_alu.sv | 177 +++++++++++++++++
 tb/tb_seq_alu.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle for the sequential ALU.
//   in_valid/in_ready : operand handshake (A, B, ALUOp travel with it)
//   out_valid/out_ready : result handshake (ALURes, illegal_op travel with it)
//   busy : an iterative multiply/divide is in progress
// master = the stage driving operands and taking results; slave = the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUOp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALURes;
  logic             illegal_op;
  logic             busy;

  modport master (
    output in_valid, A, B, ALUOp, out_ready,
    input  in_ready, out_valid, ALURes, illegal_op, busy
  );

  modport slave (
    input  in_valid, A, B, ALUOp, out_ready,
    output in_ready, out_valid, ALURes, illegal_op, busy
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU. Simple ops finish in one registered cycle; mul,
// div, divu, rem, remu iterate one bit per cycle (WIDTH cycles in BUSY).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : seq_alu_if slave (operands/op in, result/illegal_op out, busy)
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [SHW-1:0]   cnt_reg;
  logic [WIDTH-1:0] acc_reg;   // mul: partial product; div: partial remainder
  logic [WIDTH-1:0] opa_reg;   // mul: shifting multiplicand; div: dividend -> quotient
  logic [WIDTH-1:0] opb_reg;   // mul: shifting multiplier; div: divisor magnitude
  logic [WIDTH-1:0] res_reg;
  logic             illegal_reg;
  logic             is_mul_reg;
  logic             want_rem_reg;
  logic             neg_res_reg;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] quick_res;
  logic             quick_ill;
  logic             start_iter, start_mul, start_rem, start_signed;
  logic             div_by_zero, div_ovf;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign bus.in_ready   = (state_reg == IDLE) || (state_reg == DONE && bus.out_ready);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = (state_reg == DONE);
  assign bus.busy       = (state_reg == BUSY);
  assign bus.ALURes     = res_reg;
  assign bus.illegal_op = illegal_reg;

  assign shamt       = bus.B[SHW-1:0];
  assign div_by_zero = (bus.B == '0);
  // Most negative divided by -1 cannot be represented; handled without iterating.
  assign div_ovf     = (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);

  // Signed division works on magnitudes and fixes the sign on completion.
  assign a_neg = start_signed && bus.A[WIDTH-1];
  assign b_neg = start_signed && bus.B[WIDTH-1];
  assign a_mag = a_neg ? -bus.A : bus.A;
  assign b_mag = b_neg ? -bus.B : bus.B;

  // Operation decode: single-cycle results and special cases, or start of an iteration.
  always_comb begin
    quick_res    = '0;
    quick_ill    = 1'b0;
    start_iter   = 1'b0;
    start_mul    = 1'b0;
    start_rem    = 1'b0;
    start_signed = 1'b0;
    case (bus.ALUOp)
      4'b0000: quick_res = bus.A + bus.B;
      4'b1000: quick_res = bus.A - bus.B;
      4'b0001: quick_res = bus.A << shamt;
      4'b0101: quick_res = bus.A >> shamt;
      4'b1101: quick_res = $unsigned($signed(bus.A) >>> shamt);
      4'b0011: quick_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      4'b0010: quick_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      4'b0100: quick_res = bus.A ^ bus.B;
      4'b0110: quick_res = bus.A | bus.B;
      4'b0111: quick_res = bus.A & bus.B;
      4'b1110: begin
        start_iter = 1'b1;
        start_mul  = 1'b1;
      end
      4'b1001: begin
        if (div_by_zero)  quick_res = '1;
        else if (div_ovf) quick_res = bus.A;
        else begin
          start_iter   = 1'b1;
          start_signed = 1'b1;
        end
      end
      4'b1010: begin
        if (div_by_zero) quick_res = '1;
        else             start_iter = 1'b1;
      end
      4'b1011: begin
        if (div_by_zero)  quick_res = bus.A;
        else if (div_ovf) quick_res = '0;
        else begin
          start_iter   = 1'b1;
          start_signed = 1'b1;
          start_rem    = 1'b1;
        end
      end
      4'b1100: begin
        if (div_by_zero) quick_res = bus.A;
        else begin
          start_iter = 1'b1;
          start_rem  = 1'b1;
        end
      end
      default: quick_ill = 1'b1;
    endcase
  end

  // One iteration step for each datapath.
  logic [WIDTH-1:0] mul_sum, quo_step, rem_step, raw_res, iter_res;
  logic [WIDTH:0]   div_shift, div_trial;

  assign mul_sum   = acc_reg + (opb_reg[0] ? opa_reg : '0);
  assign div_shift = {acc_reg, opa_reg[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opb_reg};
  // Restoring step: a borrow (MSB set) means the divisor did not fit.
  assign rem_step  = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign quo_step  = {opa_reg[WIDTH-2:0], ~div_trial[WIDTH]};
  assign raw_res   = want_rem_reg ? rem_step : quo_step;
  assign iter_res  = is_mul_reg ? mul_sum : (neg_res_reg ? -raw_res : raw_res);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = start_iter ? BUSY : DONE;
      BUSY: if (cnt_reg == SHW'(WIDTH-1)) state_next = DONE;
      DONE: begin
        if (accept)             state_next = start_iter ? BUSY : DONE;
        else if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      acc_reg      <= '0;
      opa_reg      <= '0;
      opb_reg      <= '0;
      res_reg      <= '0;
      illegal_reg  <= 1'b0;
      is_mul_reg   <= 1'b0;
      want_rem_reg <= 1'b0;
      neg_res_reg  <= 1'b0;
    end else if (accept) begin
      cnt_reg      <= '0;
      acc_reg      <= '0;
      res_reg      <= quick_res;  // replaced on the last step of an iterative op
      illegal_reg  <= quick_ill;
      is_mul_reg   <= start_mul;
      want_rem_reg <= start_rem;
      // Quotient negative when signs differ; remainder follows the dividend.
      neg_res_reg  <= start_rem ? a_neg : (a_neg ^ b_neg);
      opa_reg      <= start_mul ? bus.A : a_mag;
      opb_reg      <= start_mul ? bus.B : b_mag;
    end else if (state_reg == BUSY) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (is_mul_reg) begin
        acc_reg <= mul_sum;
        opa_reg <= opa_reg << 1;
        opb_reg <= opb_reg >> 1;
      end else begin
        acc_reg <= rem_step;
        opa_reg <= quo_step;
      end
      if (cnt_reg == SHW'(WIDTH-1)) res_reg <= iter_res;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: checks seq_alu at WIDTH=32 and WIDTH=8 with a directed vector
// table, randomized ops against an arithmetic reference model, and
// hand-written backpressure and mid-operation reset sequences.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus32 ();
  seq_alu_if #(.WIDTH(8))  bus8 ();

  seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  int vec_count = 0;
  int miss      = 0;

  typedef struct {
    string       name;
    bit          w8;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          ill;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic at width w.
  function automatic void ref_model(input int w, input logic [3:0] op,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output bit ill, output int lat);
    longint unsigned m, ua, ub, r;
    longint sa, sb, mn;
    int sh;
    bit ovf;
    m   = (64'd1 << w) - 64'd1;
    ua  = {32'h0, a} & m;
    ub  = {32'h0, b} & m;
    sa  = ((ua >> (w-1)) & 64'd1) != 0 ? $signed(ua) - $signed(m) - 64'sd1 : $signed(ua);
    sb  = ((ub >> (w-1)) & 64'd1) != 0 ? $signed(ub) - $signed(m) - 64'sd1 : $signed(ub);
    mn  = -(64'sd1 <<< (w-1));
    ovf = (sa == mn) && (sb == -64'sd1);
    sh  = int'(ub % longint'(w));
    ill = 1'b0;
    lat = 1;
    r   = 64'd0;
    case (op)
      4'b0000: r = ua + ub;
      4'b1000: r = ua - ub;
      4'b0001: r = ua << sh;
      4'b0101: r = ua >> sh;
      4'b1101: r = $unsigned(sa >>> sh);
      4'b0011: r = (ua < ub) ? 64'd1 : 64'd0;
      4'b0010: r = (sa < sb) ? 64'd1 : 64'd0;
      4'b0100: r = ua ^ ub;
      4'b0110: r = ua | ub;
      4'b0111: r = ua & ub;
      4'b1110: begin r = ua * ub; lat = w + 1; end
      4'b1001: begin
        if (ub == 0) r = m;
        else if (ovf) r = ua;
        else begin r = $unsigned(sa / sb); lat = w + 1; end
      end
      4'b1010: begin
        if (ub == 0) r = m;
        else begin r = ua / ub; lat = w + 1; end
      end
      4'b1011: begin
        if (ub == 0) r = ua;
        else if (ovf) r = 64'd0;
        else begin r = $unsigned(sa % sb); lat = w + 1; end
      end
      4'b1100: begin
        if (ub == 0) r = ua;
        else begin r = ua % ub; lat = w + 1; end
      end
      default: ill = 1'b1;
    endcase
    r   = r & m;
    res = r[31:0];
  endfunction

  task automatic drive(input bit w8, input bit v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input bit ordy);
    if (w8) begin
      bus8.in_valid = v; bus8.ALUOp = op; bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.out_ready = ordy;
    end else begin
      bus32.in_valid = v; bus32.ALUOp = op; bus32.A = a; bus32.B = b; bus32.out_ready = ordy;
    end
  endtask

  task automatic sample(input bit w8, output logic ov, output logic ir, output logic bz,
                        output logic il, output logic [31:0] res);
    if (w8) begin
      ov = bus8.out_valid; ir = bus8.in_ready; bz = bus8.busy; il = bus8.illegal_op;
      res = {24'h0, bus8.ALURes};
    end else begin
      ov = bus32.out_valid; ir = bus32.in_ready; bz = bus32.busy; il = bus32.illegal_op;
      res = bus32.ALURes;
    end
  endtask

  // Issue one op with out_ready=1; lat counts clock edges from the accept
  // edge (inclusive) until out_valid is seen. stall_err counts cycles where
  // busy/in_ready disagree with the op's progress.
  task automatic run_op(input bit w8, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output logic il,
                        output int lat, output int stall_err);
    logic ov, ir, bz;
    stall_err = 0;
    lat = 0;
    res = '0;
    il = 1'b0;
    @(negedge clk);
    drive(w8, 1'b1, op, a, b, 1'b1);
    sample(w8, ov, ir, bz, il, res);
    if (ir !== 1'b1) stall_err++;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) drive(w8, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      lat++;
      sample(w8, ov, ir, bz, il, res);
      if (ov === 1'b1) begin
        if (bz !== 1'b0) stall_err++;
        break;
      end
      if (bz !== 1'b1 || ir !== 1'b0) stall_err++;
    end
  endtask

  task automatic do_vec(input string name, input bit w8, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input bit eill, input int elat);
    logic [31:0] res;
    logic il;
    int lat, se;
    run_op(w8, op, a, b, res, il, lat, se);
    $display("%s w=%0d op=%b a=%h b=%h -> res=%h ill=%0d lat=%0d", name, w8 ? 8 : 32, op, a, b, res, il, lat);
    chk({name, ".res"}, res, er);
    chk({name, ".ill"}, {31'h0, il}, {31'h0, eill});
    chk({name, ".lat"}, 32'(lat), 32'(elat));
    chk({name, ".stall"}, 32'(se), 32'h0);
  endtask

  initial begin
    logic [31:0] r, a, b;
    logic [3:0] op;
    bit ill, w8;
    int lat, w;

    tbl.push_back('{"add_wrap", 1'b0, 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1});
    tbl.push_back('{"sub", 1'b0, 4'b1000, 32'h5, 32'h7, 32'hFFFFFFFE, 1'b0, 1});
    tbl.push_back('{"sll", 1'b0, 4'b0001, 32'h1, 32'h24, 32'h10, 1'b0, 1});
    tbl.push_back('{"srl", 1'b0, 4'b0101, 32'h80000000, 32'h1F, 32'h1, 1'b0, 1});
    tbl.push_back('{"sra", 1'b0, 4'b1101, 32'h80000000, 32'h4, 32'hF8000000, 1'b0, 1});
    tbl.push_back('{"slt", 1'b0, 4'b0010, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1});
    tbl.push_back('{"sltu", 1'b0, 4'b0011, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1});
    tbl.push_back('{"xor", 1'b0, 4'b0100, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1});
    tbl.push_back('{"or", 1'b0, 4'b0110, 32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 1'b0, 1});
    tbl.push_back('{"and", 1'b0, 4'b0111, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1});
    tbl.push_back('{"mul", 1'b0, 4'b1110, 32'h00010003, 32'h00020005, 32'h000B000F, 1'b0, 33});
    tbl.push_back('{"div", 1'b0, 4'b1001, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b0, 33});
    tbl.push_back('{"rem", 1'b0, 4'b1011, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1'b0, 33});
    tbl.push_back('{"divu_by0", 1'b0, 4'b1010, 32'd100, 32'h0, 32'hFFFFFFFF, 1'b0, 1});
    tbl.push_back('{"div_ovf", 1'b0, 4'b1001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1});
    tbl.push_back('{"rem_ovf", 1'b0, 4'b1011, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1});
    tbl.push_back('{"remu_by0", 1'b0, 4'b1100, 32'h64, 32'h0, 32'h64, 1'b0, 1});
    tbl.push_back('{"illegal", 1'b0, 4'b1111, 32'h1234, 32'h5678, 32'h0, 1'b1, 1});
    tbl.push_back('{"divu8", 1'b1, 4'b1010, 32'd200, 32'd7, 32'd28, 1'b0, 9});
    tbl.push_back('{"mul8", 1'b1, 4'b1110, 32'd13, 32'd21, 32'd17, 1'b0, 9});
    tbl.push_back('{"div8", 1'b1, 4'b1001, 32'h9C, 32'd7, 32'hF2, 1'b0, 9});
    tbl.push_back('{"rem8", 1'b1, 4'b1011, 32'h9C, 32'd7, 32'hFE, 1'b0, 9});
    tbl.push_back('{"sra8", 1'b1, 4'b1101, 32'h80, 32'd3, 32'hF0, 1'b0, 1});
    tbl.push_back('{"divu8_by0", 1'b1, 4'b1010, 32'd55, 32'd0, 32'hFF, 1'b0, 1});

    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", {31'h0, bus32.out_valid}, 32'h0);
    chk("rst.ALURes", bus32.ALURes, 32'h0);
    chk("rst.illegal_op", {31'h0, bus32.illegal_op}, 32'h0);
    chk("rst.busy", {31'h0, bus32.busy}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", {31'h0, bus32.in_ready}, 32'h1);
    $display("reset released: in_ready=%0d out_valid=%0d", bus32.in_ready, bus32.out_valid);

    // Directed table
    foreach (tbl[i])
      do_vec(tbl[i].name, tbl[i].w8, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].ill, tbl[i].lat);

    // Randomized against the reference model, biased toward divide corner cases
    for (int i = 0; i < 240; i++) begin
      w8 = (i % 3 == 0);
      w  = w8 ? 8 : 32;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 5);
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) a = w8 ? 32'h80 : 32'h80000000;
      if (w8) begin
        a = a & 32'hFF;
        b = b & 32'hFF;
      end
      ref_model(w, op, a, b, r, ill, lat);
      do_vec($sformatf("rnd%0d", i), w8, op, a, b, r, ill, lat);
    end

    // Backpressure: hold the add result, then drain it while accepting an AND
    @(negedge clk);
    drive(1'b0, 1'b1, 4'b0000, 32'd5, 32'd7, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    chk("bp.first_valid", {31'h0, bus32.out_valid}, 32'h1);
    chk("bp.first_res", bus32.ALURes, 32'd12);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp.hold%0d.valid", k), {31'h0, bus32.out_valid}, 32'h1);
      chk($sformatf("bp.hold%0d.res", k), bus32.ALURes, 32'd12);
      chk($sformatf("bp.hold%0d.in_ready", k), {31'h0, bus32.in_ready}, 32'h0);
      $display("bp hold %0d: out_valid=%0d res=%h in_ready=%0d", k, bus32.out_valid, bus32.ALURes, bus32.in_ready);
    end
    drive(1'b0, 1'b1, 4'b0111, 32'h0000F0F0, 32'h0000FF00, 1'b1);
    #1;
    chk("bp.drain_in_ready", {31'h0, bus32.in_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    chk("bp.next_valid", {31'h0, bus32.out_valid}, 32'h1);
    chk("bp.next_res", bus32.ALURes, 32'h0000F000);
    $display("bp back-to-back: out_valid=%0d res=%h", bus32.out_valid, bus32.ALURes);
    @(posedge clk);
    @(negedge clk);
    chk("bp.drained", {31'h0, bus32.out_valid}, 32'h0);

    // Reset in the middle of a divu
    drive(1'b0, 1'b1, 4'b1010, 32'd1000, 32'd3, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    chk("mid.busy_before", {31'h0, bus32.busy}, 32'h1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid.out_valid", {31'h0, bus32.out_valid}, 32'h0);
    chk("mid.busy", {31'h0, bus32.busy}, 32'h0);
    chk("mid.in_ready", {31'h0, bus32.in_ready}, 32'h1);
    chk("mid.ALURes", bus32.ALURes, 32'h0);
    $display("reset mid-divu: out_valid=%0d busy=%0d in_ready=%0d", bus32.out_valid, bus32.busy, bus32.in_ready);
    do_vec("post_rst_add", 1'b0, 4'b0000, 32'h10, 32'h20, 32'h30, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss);
    $finish;
  end
endmodule
